// File: rtl/gbe_pkg.sv
// Shared types and default sizing for the 10GbE TX path (arbiter and packetizer).
package gbe_pkg;

    typedef logic [63:0] packet_word_t;

    typedef enum logic [1:0] {
        IDLE,
        PRI,
        SEC,
        DROP
    } arb_state_t;

    localparam int WINDOW_DEF      = 1024;
    localparam int SEC_MAX_LEN_DEF = 64;
    localparam int GUARD_DEF       = 8;

endpackage

// File: rtl/gbe_tx_arbiter.sv
// Shares the 10GbE TX port between the unstallable science packetizer and a
// handshaked housekeeping source that is only granted inside the post-packet idle gap.
//
// state | meaning
// IDLE  | no packet in flight; primary wins, else secondary may be granted
// PRI   | primary packet passing through
// SEC   | secondary packet being accepted through the one-word hold register
// DROP  | secondary packet was cut short; remaining words consumed and discarded
module gbe_tx_arbiter
    import gbe_pkg::*;
#(
    parameter int WINDOW      = WINDOW_DEF,
    parameter int SEC_MAX_LEN = SEC_MAX_LEN_DEF,
    parameter int GUARD       = GUARD_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  packet_word_t pri_data,
    input  logic         pri_valid,
    input  logic         pri_eod,
    input  packet_word_t sec_data,
    input  logic         sec_valid,
    input  logic         sec_eod,
    output logic         sec_ready,
    output packet_word_t tx_data,
    output logic         tx_valid,
    output logic         tx_eod,
    output logic         collision,
    output logic         trunc_len,
    output logic [15:0]  collision_count,
    output logic [31:0]  sec_pkt_count
);

    localparam int GAP_W = $clog2(WINDOW + 1);
    localparam int LEN_W = $clog2(SEC_MAX_LEN + 1);

    arb_state_t       state;
    logic [GAP_W-1:0] gap_cnt;
    logic             pri_seen;
    logic [LEN_W-1:0] sec_len;

    packet_word_t     p1_data;
    logic             p1_valid;
    logic             p1_eod;

    packet_word_t     hold_data;
    logic             hold_valid;
    logic             hold_eod;
    logic             hold_trunc;

    logic [31:0]      gap_need;
    logic             grant;
    logic             sec_accept;
    logic             collide;
    logic             at_max;
    logic             hold_release;

    // gap_need is 32 bits so gap + length + guard can never wrap
    always_comb begin
        gap_need     = 32'(gap_cnt) + 32'(SEC_MAX_LEN) + 32'(GUARD);
        grant        = sec_valid && !pri_valid && (!pri_seen || (gap_need <= 32'(WINDOW)));
        sec_ready    = ((state == SEC) || (state == DROP)) && !pri_valid;
        sec_accept   = sec_valid && sec_ready;
        collide      = (state == SEC) && pri_valid;
        at_max       = (sec_len == LEN_W'(SEC_MAX_LEN - 1));
        hold_release = hold_valid && (hold_eod || sec_accept || collide);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            gap_cnt         <= '0;
            pri_seen        <= 1'b0;
            sec_len         <= '0;
            p1_data         <= '0;
            p1_valid        <= 1'b0;
            p1_eod          <= 1'b0;
            hold_data       <= '0;
            hold_valid      <= 1'b0;
            hold_eod        <= 1'b0;
            hold_trunc      <= 1'b0;
            tx_data         <= '0;
            tx_valid        <= 1'b0;
            tx_eod          <= 1'b0;
            collision       <= 1'b0;
            trunc_len       <= 1'b0;
            collision_count <= '0;
            sec_pkt_count   <= '0;
        end else begin
            p1_data  <= pri_data;
            p1_valid <= pri_valid;
            p1_eod   <= pri_valid && pri_eod;

            if (pri_valid && pri_eod) begin
                gap_cnt  <= '0;
                pri_seen <= 1'b1;
            end else if (gap_cnt != GAP_W'(WINDOW)) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end

            // A held secondary word can never coincide with a primary stage-1 word:
            // the hold is only loaded on cycles where pri_valid was low.
            collision <= collide;
            trunc_len <= 1'b0;
            if (p1_valid) begin
                tx_data  <= p1_data;
                tx_valid <= 1'b1;
                tx_eod   <= p1_eod;
            end else if (hold_release) begin
                tx_data   <= hold_data;
                tx_valid  <= 1'b1;
                tx_eod    <= hold_eod || collide;
                trunc_len <= hold_trunc;
                if (hold_eod && !hold_trunc) begin
                    sec_pkt_count <= sec_pkt_count + 32'd1;
                end
            end else begin
                tx_data  <= p1_data;
                tx_valid <= 1'b0;
                tx_eod   <= 1'b0;
            end

            if (collide && (collision_count != 16'hFFFF)) begin
                collision_count <= collision_count + 16'd1;
            end

            if (hold_release) begin
                hold_valid <= 1'b0;
            end
            if ((state == SEC) && sec_accept) begin
                hold_valid <= 1'b1;
                hold_data  <= sec_data;
                hold_eod   <= sec_eod || at_max;
                hold_trunc <= !sec_eod && at_max;
            end

            case (state)
                IDLE: begin
                    sec_len <= '0;
                    if (pri_valid) begin
                        if (!pri_eod) begin
                            state <= PRI;
                        end
                    end else if (grant) begin
                        state <= SEC;
                    end
                end
                PRI: begin
                    if (pri_valid && pri_eod) begin
                        state <= IDLE;
                    end
                end
                SEC: begin
                    if (collide) begin
                        state <= DROP;
                    end else if (sec_accept) begin
                        sec_len <= sec_len + LEN_W'(1);
                        if (sec_eod) begin
                            state <= IDLE;
                        end else if (at_max) begin
                            state <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (sec_accept && sec_eod) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gbe_tx_arbiter.sv
// Scoreboard bench for gbe_tx_arbiter: stimulus pushes expected tx words with their
// due cycle, an independent monitor pops and compares whenever tx_valid is seen.
module tb_gbe_tx_arbiter;
    import gbe_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    packet_word_t pri_data;
    logic         pri_valid;
    logic         pri_eod;
    packet_word_t sec_data;
    logic         sec_valid;
    logic         sec_eod;
    logic         sec_ready;
    packet_word_t tx_data;
    logic         tx_valid;
    logic         tx_eod;
    logic         collision;
    logic         trunc_len;
    logic [15:0]  collision_count;
    logic [31:0]  sec_pkt_count;

    gbe_tx_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .pri_data        (pri_data),
        .pri_valid       (pri_valid),
        .pri_eod         (pri_eod),
        .sec_data        (sec_data),
        .sec_valid       (sec_valid),
        .sec_eod         (sec_eod),
        .sec_ready       (sec_ready),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_eod          (tx_eod),
        .collision       (collision),
        .trunc_len       (trunc_len),
        .collision_count (collision_count),
        .sec_pkt_count   (sec_pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        eod;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_eod = 0;
    int   n_coll = 0;
    int   n_trunc = 0;
    int   last_coll_cyc = -1;
    int   last_trunc_cyc = -1;
    int   n_ready = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tx_valid === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_tx: got data=%h eod=%b at cyc %0d, required no output",
                         tx_data, tx_eod, cyc);
            end else begin
                e = q.pop_front();
                if (tx_data !== e.data || tx_eod !== e.eod || cyc != e.due) begin
                    bad++;
                    $display("FAIL tx_word: got data=%h eod=%b cyc=%0d, required data=%h eod=%b cyc=%0d",
                             tx_data, tx_eod, cyc, e.data, e.eod, e.due);
                end
            end
            if (tx_eod === 1'b1) n_eod++;
        end
        if (collision === 1'b1) begin
            n_coll++;
            last_coll_cyc = cyc;
        end
        if (trunc_len === 1'b1) begin
            n_trunc++;
            last_trunc_cyc = cyc;
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    function automatic logic [63:0] pdat(input int id, input int i);
        return {16'hA5A5, id[15:0], i[31:0]};
    endfunction

    function automatic logic [63:0] sdat(input int id, input int i);
        return {16'h5EC0, id[15:0], i[31:0]};
    endfunction

    // Drives one cycle of inputs at the falling edge; acc reports whether the
    // secondary word will be taken at the coming rising edge.
    task automatic step(input logic pv, input logic [63:0] pd, input logic pe,
                        input logic sv, input logic [63:0] sd, input logic se,
                        output logic acc);
        @(negedge clk);
        pri_valid = pv;
        pri_data  = pd;
        pri_eod   = pe;
        sec_valid = sv;
        sec_data  = sd;
        sec_eod   = se;
        #1;
        acc = sv && sec_ready;
        if (sec_ready === 1'b1) n_ready++;
        if (pv) q.push_back('{pd, pe, cyc + 2});
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, acc);
    endtask

    task automatic pri_pkt(input int id, input int len);
        logic acc;
        for (int k = 0; k < len; k++) step(1'b1, pdat(id, k), k == len - 1, 1'b0, '0, 1'b0, acc);
    endtask

    // Offers a len-word secondary packet; the first n_push words are expected on tx,
    // with eod on word eod_idx.
    task automatic send_sec(input int id, input int len, input int n_push, input int eod_idx,
                            output int eod_due);
        int   i = 0;
        int   guard = 0;
        logic acc;
        eod_due = -1;
        while (i < len && guard < 400) begin
            step(1'b0, '0, 1'b0, 1'b1, sdat(id, i), i == len - 1, acc);
            if (acc) begin
                if (i < n_push) q.push_back('{sdat(id, i), i == eod_idx, cyc + 2});
                if (i == eod_idx) eod_due = cyc + 2;
                i++;
            end
            guard++;
        end
        check("sec_words_accepted", i, len);
    endtask

    int   snap_eod, snap_coll, snap_trunc, snap_ready;
    int   due, w4_due, bad_acc;
    logic acc;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pri_valid = 1'b0; pri_data = '0; pri_eod = 1'b0;
        sec_valid = 1'b0; sec_data = '0; sec_eod = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", int'(tx_valid), 0);
        check("rst_sec_ready", int'(sec_ready), 0);
        check("rst_tx_data_lo", int'(tx_data[31:0]), 0);
        check("rst_counts", int'(collision_count) + int'(sec_pkt_count), 0);
        rst = 1'b0;
        idle(2);

        // over-length secondary before any primary: 64 out, last with forced eod
        snap_trunc = n_trunc;
        send_sec(1, 70, 64, 63, due);
        idle(4);
        check("trunc_pulses", n_trunc - snap_trunc, 1);
        check("trunc_pulse_cycle", last_trunc_cyc, due);
        check("trunc_pkt_count", int'(sec_pkt_count), 0);

        // collision: primary arrives while secondary word 5 is offered
        snap_coll = n_coll;
        begin
            int i = 0;
            int g = 0;
            while (i < 5 && g < 100) begin
                step(1'b0, '0, 1'b0, 1'b1, sdat(2, i), 1'b0, acc);
                if (acc) begin
                    q.push_back('{sdat(2, i), i == 4, cyc + 2});
                    if (i == 4) w4_due = cyc + 2;
                    i++;
                end
                g++;
            end
            check("coll_prefix_accepted", i, 5);
            bad_acc = 0;
            for (int k = 0; k < 16; k++) begin
                step(1'b1, pdat(3, k), k == 15, 1'b1, sdat(2, 5), 1'b0, acc);
                if (acc) bad_acc++;
            end
            check("coll_no_accept_during_pri", bad_acc, 0);
            i = 5;
            g = 0;
            while (i < 32 && g < 100) begin
                step(1'b0, '0, 1'b0, 1'b1, sdat(2, i), i == 31, acc);
                if (acc) i++;
                g++;
            end
            check("coll_remainder_consumed", i, 32);
        end
        idle(4);
        check("coll_pulses", n_coll - snap_coll, 1);
        check("coll_pulse_cycle", last_coll_cyc, w4_due);
        check("coll_count", int'(collision_count), 1);
        check("coll_pkt_count", int'(sec_pkt_count), 0);

        // primary only: three full bursts each followed by the idle window
        snap_eod = n_eod;
        snap_ready = n_ready;
        for (int r = 0; r < 3; r++) begin
            pri_pkt(10 + r, 1024);
            idle(1024);
        end
        check("pri_only_eods", n_eod - snap_eod, 3);
        check("pri_only_sec_ready", n_ready - snap_ready, 0);

        // secondary early in the gap
        pri_pkt(20, 4);
        idle(10);
        snap_eod = n_eod;
        send_sec(21, 16, 16, 15, due);
        idle(4);
        check("gap_pkt_count", int'(sec_pkt_count), 1);
        check("gap_eods", n_eod - snap_eod, 1);

        // late request: no grant near the end of the window, granted after next primary
        pri_pkt(30, 4);
        idle(1000);
        bad_acc = 0;
        snap_ready = n_ready;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, '0, 1'b0, 1'b1, sdat(31, 0), 1'b0, acc);
            if (acc) bad_acc++;
        end
        check("late_no_grant", bad_acc + n_ready - snap_ready, 0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, pdat(32, k), k == 7, 1'b1, sdat(31, 0), 1'b0, acc);
            if (acc) bad_acc++;
        end
        check("late_no_accept_during_pri", bad_acc, 0);
        send_sec(31, 16, 16, 15, due);
        idle(4);
        check("late_pkt_count", int'(sec_pkt_count), 2);

        // reset in the middle of a secondary packet
        begin
            int i = 0;
            int g = 0;
            while (i < 3 && g < 100) begin
                step(1'b0, '0, 1'b0, 1'b1, sdat(40, i), 1'b0, acc);
                if (acc) begin
                    q.push_back('{sdat(40, i), 1'b0, cyc + 2});
                    i++;
                end
                g++;
            end
            check("rst_prefix_accepted", i, 3);
        end
        @(negedge clk);
        rst = 1'b1;
        sec_valid = 1'b1;
        sec_data = sdat(40, 3);
        #1;
        while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
        @(negedge clk);
        check("mid_rst_tx_valid", int'(tx_valid), 0);
        check("mid_rst_tx_eod", int'(tx_eod), 0);
        check("mid_rst_tx_data_lo", int'(tx_data[31:0]), 0);
        check("mid_rst_sec_ready", int'(sec_ready), 0);
        check("mid_rst_pulses", int'(collision) + int'(trunc_len), 0);
        check("mid_rst_coll_count", int'(collision_count), 0);
        check("mid_rst_pkt_count", int'(sec_pkt_count), 0);
        check("mid_rst_state", int'(dut.state), int'(IDLE));
        check("mid_rst_pri_seen", int'(dut.pri_seen), 0);
        rst = 1'b0;
        idle(6);

        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gbe_tx_arbiter.md
Name: gbe_tx_arbiter

Overview:
- Shares the single CASPER 10GbE TX port (64-bit data/valid/eod) between two sources.
- Primary source: the science packetizer. It cannot be stalled and emits 1024-word bursts at a fixed cadence.
- Secondary source: a low-rate, handshaked housekeeping/heartbeat packet source. It is granted only inside the idle gap that follows each primary packet.
- Every emitted packet is atomic and correctly terminated with tx_eod. Collisions are truncated cleanly and flagged.

Parameters:
- WINDOW, 1024: guaranteed idle cycles after a primary tx_eod before the next primary word.
- SEC_MAX_LEN, 64: maximum secondary packet length in words, range 1..WINDOW.
- GUARD, 8: safety margin in cycles subtracted from the window.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pri_data  in  64  primary word
- pri_valid  in  1  primary word valid; cannot be backpressured
- pri_eod  in  1  last primary word of packet
- sec_data  in  64  secondary word
- sec_valid  in  1  secondary word valid
- sec_eod  in  1  last secondary word
- sec_ready  out  1  secondary word accepted when sec_valid && sec_ready
- tx_data  out  64  to 10GbE core
- tx_valid  out  1  output word valid
- tx_eod  out  1  end of packet
- collision  out  1  one-cycle pulse: secondary packet truncated by primary
- trunc_len  out  1  one-cycle pulse: secondary packet truncated at SEC_MAX_LEN
- collision_count  out  16  saturating count of collision pulses
- sec_pkt_count  out  32  secondary packets emitted, wraps

Behaviour:
- Reset values:
  - tx_data=0, tx_valid=0, tx_eod=0, sec_ready=0.
  - collision=0, trunc_len=0, collision_count=0, sec_pkt_count=0.
  - FSM=IDLE, gap_cnt=0, pri_seen=0, hold stage empty.
  - Reset mid-packet aborts the packet immediately; no eod is emitted.
- Latency: both paths take exactly 2 cycles from input to tx_*. There is a stage-1 register per path, then one shared output register.
- gap_cnt:
  - Cleared on a primary word with pri_eod.
  - Otherwise increments, saturating at WINDOW.
  - pri_seen is set on the first pri_eod.
- Grant condition: sec_valid && !pri_valid && (!pri_seen || gap_cnt + SEC_MAX_LEN + GUARD <= WINDOW). Compute in a width wide enough that the sum cannot overflow.
- FSM states:
  - IDLE: sec_ready=0.
    - pri_valid -> PRI.
    - Else grant -> SEC.
  - PRI: primary words pass through; sec_ready=0. Leave to IDLE on the pri_eod word.
  - SEC: sec_ready = !pri_valid.
    - Each accepted word enters the secondary hold register (1 word).
    - The held word is released to stage 2 only when the next word is accepted, or carries its own eod.
    - Accepted word with sec_eod -> sec_pkt_count++ when it is output; return to IDLE.
    - pri_valid while in SEC (collision): the held word is released with tx_eod forced to 1, collision pulses, and the FSM goes to DROP. The primary word is captured in its stage 1 that same cycle and reaches tx one cycle after the forced-eod word, so there is no overlap and no gap requirement.
    - If the hold register is empty at a collision (no word accepted yet), nothing is emitted and the collision pulse still fires.
    - SEC_MAX_LEN-th accepted word without eod: that word is output with forced tx_eod, trunc_len pulses, and the FSM goes to DROP.
  - DROP: sec_ready = !pri_valid; accepted words are discarded. Leave to IDLE on an accepted sec_eod.
    - Primary words are forwarded normally while in DROP.
    - Truncated packets do not increment sec_pkt_count.
- Priority on the same cycle: primary > secondary grant. Primary always passes and is never dropped.
- Primary input words arriving in PRI with pri_valid low mid-packet produce tx_valid=0 bubbles, passed through unchanged.
- The forced-eod and the normal sec_eod pulse on the same word produce a single eod.

Decomposition:
- Shared package gbe_pkg holds:
  - the packet_word_t (64-bit) typedef;
  - the arb_state_t enum {IDLE, PRI, SEC, DROP};
  - the default WINDOW and SEC_MAX_LEN constants, also used by the packetizer.
- No sub-module; the hold register and counters are inline.

Test Plan:
- Primary only: 1024-word burst with eod on the last word, then 1024 idle cycles, repeated 3 times -> tx mirrors input delayed by 2 cycles; tx_eod 3 times; sec_ready stays 0.
- Secondary in the gap: after pri_eod, offer a 16-word sec packet at gap_cnt=10 -> granted; 16 tx words, the last with eod; sec_pkt_count=1.
- Late request: sec_valid at gap_cnt=1000 (WINDOW=1024, SEC_MAX_LEN=64, GUARD=8) -> no grant until after the next primary packet, then granted.
- Collision (before pri_seen, or with the window set wrong): 32-word sec packet, pri_valid at sec word 5 -> words 0..4 emitted, word 4 with eod; collision=1 for 1 cycle; primary packet intact 1 cycle later; remainder dropped; collision_count=1.
- Over-length: 70-word sec packet, SEC_MAX_LEN=64 -> 64 words out, the 64th with eod; trunc_len pulse; words 65..70 consumed; sec_pkt_count unchanged.
- Reset mid-SEC at word 3 -> next cycle all outputs 0, FSM IDLE, counts 0, pri_seen=0.
